fifo_wr_arb: RTL and testbench
==============================

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter N, default 4, number of write requesters sharing the FIFO write port.
REQ-002 Parameter DW, default 8, data width, equal to the FIFO write-data width.
REQ-003 Parameter MAX_BURST, default 4, maximum words one grant may transfer (range 1..15).
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Port req  input  N  per-requester write request; bit i held while requester i has data.
REQ-007 Port din  input  N*DW  packed requester data; slice i = din[i*DW +: DW].
REQ-008 Port gnt  output  N  registered one-hot grant; all-zero when no owner.
REQ-009 Port ack  output  N  combinational per-requester word-accepted strobe.
REQ-010 Port f  input  1  FIFO full flag.
REQ-011 Port WREQ  output  1  FIFO write request.
REQ-012 Port WD  output  DW  FIFO write data.
REQ-013 Port busy  output  1  high while state is BURST.

Function
REQ-014 The block SHALL implement two states, IDLE and BURST, plus a log2(N)-bit round-robin pointer ptr and a 4-bit beat counter cnt.
REQ-015 In IDLE with req != 0, the block SHALL select the first set req bit searching from index ptr upward with wrap (ptr, ptr+1, ..., N-1, 0, ...), register that index as owner, set gnt to one-hot(owner), clear cnt, and enter BURST on the next edge.
REQ-016 In IDLE with req == 0, the block SHALL stay in IDLE with gnt = 0.
REQ-017 In BURST, WREQ SHALL be req[owner] AND NOT f, combinationally; WD SHALL equal din slice owner whenever state is BURST.
REQ-018 ack[owner] SHALL equal WREQ; every other ack bit, and all ack bits in IDLE, SHALL be 0.
REQ-019 Each cycle with WREQ = 1, cnt SHALL increment by 1; cycles with f = 1 SHALL NOT increment cnt (stall with grant held).
REQ-020 BURST SHALL end, returning to IDLE on the next edge with gnt cleared, when either (a) WREQ = 1 and cnt = MAX_BURST-1 (last beat), or (b) req[owner] = 0.
REQ-021 On leaving BURST, ptr SHALL become (owner+1) mod N.
REQ-022 The arbitration cycle SHALL cost exactly one IDLE cycle between bursts; req-to-first-WREQ latency from IDLE SHALL be 1 cycle.
REQ-023 Requests from non-owners during BURST SHALL NOT affect gnt, WREQ, WD or cnt.
REQ-024 Last beat coinciding with req[owner] falling SHALL be treated as one end event (IDLE next cycle, ptr advanced once).
REQ-025 f held high for any number of cycles SHALL hold BURST, owner and cnt unchanged, with WREQ = 0.
REQ-026 gnt SHALL never have more than one bit set, and WREQ SHALL never be 1 while f = 1.

Reset
REQ-027 With rst = 1 at a rising edge, state SHALL become IDLE, gnt = 0, ptr = 0, cnt = 0, owner = 0; WREQ, ack and busy SHALL therefore read 0.
REQ-028 rst asserted mid-burst SHALL abort the burst at that edge with no further WREQ; words already accepted are not retracted.

Verification
REQ-029 Reset, then req = 4'b0001, f = 0, held -> gnt = 0001 one cycle later, WREQ high 4 consecutive cycles with WD = din[7:0], then 1 IDLE cycle, then grant again to 0001 (sole requester).
REQ-030 req = 4'b1111 held, f = 0 -> grant order 0001, 0010, 0100, 1000, 0001; each burst 4 words, 1 IDLE cycle between bursts.
REQ-031 Owner 2 in BURST after 2 words, f = 1 for 3 cycles -> WREQ = 0, gnt = 0100 held, ack = 0; after f drops, exactly 2 more words, then IDLE.
REQ-032 Owner 1 drops req after 1 word with req[3] high -> IDLE next cycle, ptr = 2, next grant = 1000.
REQ-033 rst pulsed for 1 cycle during BURST at cnt = 2 -> next cycle gnt = 0, WREQ = 0, busy = 0; next grant from ptr = 0.
REQ-034 Random req/f stimulus for 10k cycles -> gnt one-hot or zero, no WREQ with f = 1, no burst longer than MAX_BURST words, every continuously-requesting requester granted within N bursts.

Source files
------------

// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter: N requesters share one FIFO write port, each grant
// moves at most MAX_BURST words and a full FIFO stalls the burst in place.
//
// state | meaning
// IDLE  | no owner, gnt = 0; picks next requester from ptr with wrap
// BURST | owner holds the write port until last beat or its req drops
module fifo_wr_arb #(
  parameter int N         = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N*DW-1:0] din,
  output logic [N-1:0]    gnt,
  output logic [N-1:0]    ack,
  input  logic            f,
  output logic            WREQ,
  output logic [DW-1:0]   WD,
  output logic            busy
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [N-1:0]    gnt_q, gnt_d;

  logic [PW-1:0]   pick;
  logic [PW-1:0]   idx;
  logic            found;
  logic            req_own;
  logic [DW-1:0]   wd_own;
  logic            in_burst;
  logic            last_beat;
  logic            burst_end;

  // Descending scan so the lowest offset from ptr is the one left in pick.
  always_comb begin
    pick  = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int k = N-1; k >= 0; k--) begin
      idx = PW'((int'(ptr_q) + k) % N);
      if (req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    req_own = 1'b0;
    wd_own  = '0;
    for (int i = 0; i < N; i++) begin
      if (owner_q == PW'(i)) begin
        req_own = req[i];
        wd_own  = din[i*DW +: DW];
      end
    end
  end

  assign in_burst  = (state_q == BURST);
  assign WREQ      = in_burst & req_own & ~f;
  assign WD        = in_burst ? wd_own : '0;
  assign busy      = in_burst;
  assign gnt       = gnt_q;
  assign last_beat = WREQ && (cnt_q == 4'(MAX_BURST-1));
  // Last beat and req drop in the same cycle collapse into one end event.
  assign burst_end = last_beat || !req_own;

  always_comb begin
    ack = '0;
    for (int i = 0; i < N; i++) begin
      ack[i] = WREQ && (owner_q == PW'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (found) begin
          state_d = BURST;
          owner_d = pick;
          cnt_d   = '0;
          for (int i = 0; i < N; i++) begin
            gnt_d[i] = (pick == PW'(i));
          end
        end
      end
      BURST: begin
        if (WREQ) begin
          cnt_d = cnt_q + 4'd1;
        end
        if (burst_end) begin
          state_d = IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
          ptr_d   = (owner_q == PW'(N-1)) ? '0 : owner_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: directed scenarios plus a long random run, all compared
// against a word-counting reference model of the arbitration rules.
module tb_fifo_wr_arb;

  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int MB   = 4;
  localparam int DINW = N*DW;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [DINW-1:0] din;
  logic            f;
  logic [N-1:0]    gnt, ack;
  logic            wreq;
  logic [DW-1:0]   wd;
  logic            busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_wr_arb #(.N(N), .DW(DW), .MAX_BURST(MB)) dut (
    .clk (clk), .rst (rst), .req (req), .din (din), .gnt (gnt), .ack (ack),
    .f (f), .WREQ (wreq), .WD (wd), .busy (busy)
  );

  // Reference model: who owns the port, how many words it has moved, where the
  // next search starts.
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_ptr   = 0;
  int m_words = 0;

  logic [N-1:0]  exp_gnt, exp_ack;
  logic          exp_wreq, exp_busy;
  logic [DW-1:0] exp_wd;

  task automatic model_expect();
    exp_busy = m_busy;
    exp_gnt  = '0;
    exp_ack  = '0;
    exp_wreq = 1'b0;
    exp_wd   = '0;
    if (m_busy) begin
      exp_gnt[m_owner] = 1'b1;
      exp_wreq = req[m_owner] && !f;
      exp_wd   = DW'(din >> (m_owner*DW));
      if (exp_wreq) exp_ack[m_owner] = 1'b1;
    end
  endtask

  task automatic model_tick();
    bit done;
    model_expect();
    if (rst) begin
      m_busy = 0; m_ptr = 0; m_owner = 0; m_words = 0;
    end else if (!m_busy) begin
      if (req != '0) begin
        for (int k = 0; k < N; k++) begin
          if (req[(m_ptr+k)%N]) begin
            m_owner = (m_ptr+k)%N;
            break;
          end
        end
        m_busy  = 1;
        m_words = 0;
      end
    end else begin
      if (exp_wreq) m_words++;
      done = (exp_wreq && m_words == MB) || !req[m_owner];
      if (done) begin
        m_busy = 0;
        m_ptr  = (m_owner+1)%N;
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; f = 1'b0; din = '0;
    advance();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = N'($urandom); f = 1'b0; din = DINW'($urandom);
    advance();
    req = '1;
    for (int c = 0; c < 3; c++) begin
      din = DINW'($urandom);
      #1;
      checks++;
      if (gnt !== '0 || wreq !== 1'b0 || ack !== '0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold c%0d: gnt=%b wreq=%b ack=%b busy=%b, required all zero", c, gnt, wreq, ack, busy);
      end
      advance();
    end
    rst = 1'b0; req = '0;
    #1;
    model_expect();
    checks++;
    if ({gnt, ack, wreq, wd, busy} !== {exp_gnt, exp_ack, exp_wreq, exp_wd, exp_busy}) begin
      errors++;
      $display("FAIL reset_state: gnt=%b ack=%b wreq=%b wd=%h busy=%b, required %b %b %b %h %b",
               gnt, ack, wreq, wd, busy, exp_gnt, exp_ack, exp_wreq, exp_wd, exp_busy);
    end
  endtask

  task automatic test_single();
    logic [7:0]   wseq;
    logic [N-1:0] g6;
    do_reset();
    req = 4'b0001;
    wseq = '0; g6 = '0;
    for (int c = 0; c < 8; c++) begin
      din = DINW'($urandom);
      #1;
      model_expect();
      checks++;
      if ({gnt, ack, wreq, wd, busy} !== {exp_gnt, exp_ack, exp_wreq, exp_wd, exp_busy}) begin
        errors++;
        $display("FAIL single c%0d: gnt=%b ack=%b wreq=%b wd=%h busy=%b, required %b %b %b %h %b",
                 c, gnt, ack, wreq, wd, busy, exp_gnt, exp_ack, exp_wreq, exp_wd, exp_busy);
      end
      wseq[c] = wreq;
      if (c == 6) g6 = gnt;
      advance();
    end
    checks++;
    if (wseq !== 8'b1101_1110) begin
      errors++;
      $display("FAIL single_wreq_seq: got %b, required 11011110", wseq);
    end
    checks++;
    if (g6 !== 4'b0001) begin
      errors++;
      $display("FAIL single_regrant: gnt=%b, required 0001", g6);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] order[$];
    int           lens[$];
    int           words;
    bit           prev_busy;
    logic [N-1:0] exp_order [5];
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    req = '1; prev_busy = 0; words = 0;
    for (int c = 0; c < 26; c++) begin
      din = DINW'($urandom);
      #1;
      model_expect();
      checks++;
      if ({gnt, ack, wreq, wd, busy} !== {exp_gnt, exp_ack, exp_wreq, exp_wd, exp_busy}) begin
        errors++;
        $display("FAIL rr c%0d: gnt=%b ack=%b wreq=%b wd=%h busy=%b, required %b %b %b %h %b",
                 c, gnt, ack, wreq, wd, busy, exp_gnt, exp_ack, exp_wreq, exp_wd, exp_busy);
      end
      if (busy && !prev_busy) order.push_back(gnt);
      if (!busy && prev_busy) begin lens.push_back(words); words = 0; end
      if (wreq) words++;
      prev_busy = busy;
      advance();
    end
    checks++;
    if (order.size() != 5) begin
      errors++;
      $display("FAIL rr_count: %0d grants, required 5", order.size());
    end
    for (int i = 0; i < order.size() && i < 5; i++) begin
      checks++;
      if (order[i] !== exp_order[i]) begin
        errors++;
        $display("FAIL rr_order[%0d]: gnt=%b, required %b", i, order[i], exp_order[i]);
      end
    end
    foreach (lens[i]) begin
      checks++;
      if (lens[i] != MB) begin
        errors++;
        $display("FAIL rr_len[%0d]: %0d words, required %0d", i, lens[i], MB);
      end
    end
  endtask

  task automatic test_stall();
    int after;
    do_reset();
    req = 4'b0100; after = 0;
    for (int c = 0; c < 10; c++) begin
      f   = (c >= 3 && c <= 5);
      din = DINW'($urandom);
      #1;
      model_expect();
      checks++;
      if ({gnt, ack, wreq, wd, busy} !== {exp_gnt, exp_ack, exp_wreq, exp_wd, exp_busy}) begin
        errors++;
        $display("FAIL stall c%0d: gnt=%b ack=%b wreq=%b wd=%h busy=%b, required %b %b %b %h %b",
                 c, gnt, ack, wreq, wd, busy, exp_gnt, exp_ack, exp_wreq, exp_wd, exp_busy);
      end
      if (c >= 3 && c <= 5) begin
        checks++;
        if (wreq !== 1'b0 || gnt !== 4'b0100 || ack !== '0) begin
          errors++;
          $display("FAIL stall_hold c%0d: wreq=%b gnt=%b ack=%b, required 0 0100 0000", c, wreq, gnt, ack);
        end
      end
      if (c >= 6 && c <= 8 && wreq) after++;
      if (c == 8) begin
        checks++;
        if (gnt !== '0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL stall_end: gnt=%b busy=%b, required 0000 0", gnt, busy);
        end
      end
      advance();
    end
    f = 1'b0;
    checks++;
    if (after != 2) begin
      errors++;
      $display("FAIL stall_words: %0d words after release, required 2", after);
    end
  endtask

  task automatic test_drop();
    logic [N-1:0] req_seq [5];
    req_seq = '{4'b1010, 4'b1010, 4'b1000, 4'b1001, 4'b1001};
    do_reset();
    for (int c = 0; c < 5; c++) begin
      req = req_seq[c];
      din = DINW'($urandom);
      #1;
      model_expect();
      checks++;
      if ({gnt, ack, wreq, wd, busy} !== {exp_gnt, exp_ack, exp_wreq, exp_wd, exp_busy}) begin
        errors++;
        $display("FAIL drop c%0d: gnt=%b ack=%b wreq=%b wd=%h busy=%b, required %b %b %b %h %b",
                 c, gnt, ack, wreq, wd, busy, exp_gnt, exp_ack, exp_wreq, exp_wd, exp_busy);
      end
      if (c == 3) begin
        checks++;
        if (gnt !== '0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL drop_idle: gnt=%b busy=%b, required 0000 0", gnt, busy);
        end
      end
      if (c == 4) begin
        checks++;
        if (gnt !== 4'b1000) begin
          errors++;
          $display("FAIL drop_next_grant: gnt=%b, required 1000", gnt);
        end
      end
      advance();
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    req = '1;
    for (int c = 0; c < 11; c++) begin
      rst = (c == 8);
      din = DINW'($urandom);
      #1;
      model_expect();
      checks++;
      if ({gnt, ack, wreq, wd, busy} !== {exp_gnt, exp_ack, exp_wreq, exp_wd, exp_busy}) begin
        errors++;
        $display("FAIL rst_mid c%0d: gnt=%b ack=%b wreq=%b wd=%h busy=%b, required %b %b %b %h %b",
                 c, gnt, ack, wreq, wd, busy, exp_gnt, exp_ack, exp_wreq, exp_wd, exp_busy);
      end
      if (c == 9) begin
        checks++;
        if (gnt !== '0 || wreq !== 1'b0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL rst_mid_abort: gnt=%b wreq=%b busy=%b, required 0000 0 0", gnt, wreq, busy);
        end
      end
      if (c == 10) begin
        checks++;
        if (gnt !== 4'b0001) begin
          errors++;
          $display("FAIL rst_mid_ptr: gnt=%b, required 0001", gnt);
        end
      end
      advance();
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    int           bw;
    int           waits [N];
    bit           prev_busy;
    logic [N-1:0] prev_req;
    do_reset();
    req = '0; bw = 0; prev_busy = 0; prev_req = '0;
    foreach (waits[i]) waits[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(7) == 0) req[i] = ~req[i];
      f   = ($urandom_range(3) == 0);
      din = DINW'({$urandom, $urandom});
      #1;
      model_expect();
      checks++;
      if ({gnt, ack, wreq, wd, busy} !== {exp_gnt, exp_ack, exp_wreq, exp_wd, exp_busy}) begin
        errors++;
        $display("FAIL random c%0d: gnt=%b ack=%b wreq=%b wd=%h busy=%b, required %b %b %b %h %b",
                 c, gnt, ack, wreq, wd, busy, exp_gnt, exp_ack, exp_wreq, exp_wd, exp_busy);
      end
      checks++;
      if ($countones(gnt) > 1) begin
        errors++;
        $display("FAIL random_onehot c%0d: gnt=%b, required at most one bit", c, gnt);
      end
      checks++;
      if (wreq && f) begin
        errors++;
        $display("FAIL random_wreq_full c%0d: wreq=%b f=%b, required wreq 0 when full", c, wreq, f);
      end
      if (!busy) bw = 0;
      else if (wreq) bw++;
      checks++;
      if (bw > MB) begin
        errors++;
        $display("FAIL random_burst_len c%0d: %0d words, required at most %0d", c, bw, MB);
      end
      for (int i = 0; i < N; i++) if (!req[i]) waits[i] = 0;
      if (busy && !prev_busy) begin
        for (int i = 0; i < N; i++) begin
          if (gnt[i]) waits[i] = 0;
          else if (prev_req[i] && req[i]) begin
            waits[i]++;
            checks++;
            if (waits[i] > N-1) begin
              errors++;
              $display("FAIL random_fair c%0d: requester %0d passed over %0d times, required at most %0d",
                       c, i, waits[i], N-1);
            end
          end
        end
      end
      prev_busy = busy;
      prev_req  = req;
      advance();
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; f = 1'b0; din = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_drop();
    test_rst_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
